// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall controller for the 5-stage MIPS pipeline.
//
// Detects load-use hazards that EX/MEM forwarding cannot cover. Sequences
// multi-cycle EX operations with a down-counter. Drives the per-stage hold
// vector for pc_reg, if_id, id_ex, ex_mem and mem_wb.
//
// Ports:
//   clk, rst          core clock; synchronous active-high reset
//   id_reg*_read_i    decode reads source operand 1/2
//   id_reg*_addr_i    decode source register addresses
//   ex_wreg_i         EX instruction writes a register
//   ex_wd_i           EX destination register
//   ex_is_load_i      EX instruction is a load
//   ex_mc_start_i     EX begins a multi-cycle op this cycle
//   ex_mc_len_i       total EX cycles of that op, including the start cycle
//   flush_i           exception/redirect flush, aborts any sequence
//   stall_o           {WB,MEM,EX,ID,IF,PC} hold bits
//   mc_last_o         final cycle of a multi-cycle op
//   busy_o            multi-cycle op in progress (MC_RUN)
//   mc_cnt_o          counter value, for debug
//   stall_cycles_o    cycles with stall_o[0] set, saturating
//                     (present only when STALL_PERF_CNT_EN is defined)
//
// Optional feature macro: STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read_i,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic             id_reg2_read_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             ex_wreg_i,
  input  logic [4:0]       ex_wd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_mc_start_i,
  input  logic [CNT_W-1:0] ex_mc_len_i,
  input  logic             flush_i,
  output logic [5:0]       stall_o,
  output logic             mc_last_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] mc_cnt_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles_o
`endif
);

  localparam logic [5:0] StallLoadUse = 6'b000111;
  localparam logic [5:0] StallMc      = 6'b001111;

  typedef enum logic [0:0] {StIdle, StMcRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             mc_long;

  // $0 is hardwired to zero, so it never carries a real dependency.
  assign load_use = ex_wreg_i && ex_is_load_i && (ex_wd_i != 5'd0) &&
                    ((id_reg1_read_i && (id_reg1_addr_i == ex_wd_i)) ||
                     (id_reg2_read_i && (id_reg2_addr_i == ex_wd_i)));

  assign mc_long = ex_mc_len_i >= CNT_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ex_mc_start_i && mc_long) begin
            state_d = StMcRun;
            cnt_d   = ex_mc_len_i - CNT_W'(1);
          end
        end
        StMcRun: begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Reset gates the outputs so they read zero even before the first edge.
  always_comb begin
    stall_o   = '0;
    mc_last_o = 1'b0;
    busy_o    = 1'b0;
    mc_cnt_o  = '0;
    if (!rst) begin
      busy_o   = (state_q == StMcRun);
      mc_cnt_o = cnt_q;
      if (!flush_i) begin
        unique case (state_q)
          StIdle: begin
            // A start takes priority over load-use; a 0/1-cycle op finishes at once.
            if (ex_mc_start_i) begin
              if (mc_long) stall_o = StallMc;
              else         mc_last_o = 1'b1;
            end else if (load_use) begin
              stall_o = StallLoadUse;
            end
          end
          StMcRun: begin
            if (cnt_q > CNT_W'(1)) stall_o = StallMc;
            else                   mc_last_o = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall_o[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule
